// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state encoding and index helpers for the port arbiter
package arb_pkg;

    localparam int NREQ = 4;
    localparam int IDXW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [IDXW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDXW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at ptr, skipping masked requesters
module rr_pick
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic [3:0] mask,
    output logic       valid,
    output logic [1:0] idx
);

    logic [3:0] eligible;
    logic [1:0] cand;

    assign eligible = req & ~mask;

    // Walk the search order backwards so the candidate closest to ptr is written last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + k[1:0];
            if (eligible[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin owner of a shared memory port; optional ARB_TIMEOUT_EN forces release after MAX_HOLD cycles
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    if (N < 1 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("mem_port_arbiter: N must be positive and MAX_HOLD within 2..255");
    end

    arb_state_e state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;

    logic       end_tenure;
    logic       hold_expire;
    logic [1:0] pick_ptr;
    logic [3:0] pick_mask;
    logic       pick_valid;
    logic [1:0] pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    assign hold_expire = (hold_q == HOLD_LAST);
`else
    assign hold_expire = 1'b0;
`endif

    // On end of tenure the pick reruns from the owner's successor with the owner masked out.
    always_comb begin
        end_tenure = (state_q == OWN) && (done || !req[sel_q] || hold_expire);
        pick_ptr   = end_tenure ? sel_q + 2'd1 : ptr_q;
        pick_mask  = end_tenure ? idx_to_onehot(sel_q) : 4'b0000;
    end

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    gnt_d   = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                end
            end
            OWN: begin
                if (end_tenure) begin
                    ptr_d = pick_ptr;
                    if (pick_valid) begin
                        gnt_d = idx_to_onehot(pick_idx);
                        sel_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Counter restarts on every handover so each owner gets a full MAX_HOLD window.
    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (end_tenure || (state_q == IDLE && pick_valid)) begin
            hold_d    = 8'd0;
            timeout_d = hold_expire && !done;
        end else if (state_q == OWN) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = |gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int checks;
    int failures;

    mem_port_arbiter #(
        .N        (32),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] sel;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] eg, input logic [1:0] es,
                                 input logic et);
        chk({tag, " gnt"}, 32'(gnt), 32'(eg));
        chk({tag, " sel"}, 32'(sel), 32'(es));
        chk({tag, " busy"}, 32'(busy), 32'(|eg));
        chk({tag, " timeout"}, 32'(timeout), 32'(et));
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        done     = 1'b0;

        vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 2'd0};
        vecs[1]  = '{4'b0001, 1'b1, 4'b0000, 2'd0};
        vecs[2]  = '{4'b0101, 1'b0, 4'b0100, 2'd2};
        vecs[3]  = '{4'b0101, 1'b1, 4'b0001, 2'd0};
        vecs[4]  = '{4'b0101, 1'b1, 4'b0100, 2'd2};
        vecs[5]  = '{4'b1011, 1'b0, 4'b1000, 2'd3};
        vecs[6]  = '{4'b1011, 1'b0, 4'b1000, 2'd3};
        vecs[7]  = '{4'b1111, 1'b0, 4'b1000, 2'd3};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        vecs[9]  = '{4'b1111, 1'b1, 4'b0010, 2'd1};
        vecs[10] = '{4'b1111, 1'b1, 4'b0100, 2'd2};
        vecs[11] = '{4'b1111, 1'b1, 4'b1000, 2'd3};
        vecs[12] = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        vecs[13] = '{4'b0001, 1'b1, 4'b0000, 2'd0};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
        vecs[15] = '{4'b1000, 1'b0, 4'b1000, 2'd3};
        vecs[16] = '{4'b1000, 1'b1, 4'b0000, 2'd3};
        vecs[17] = '{4'b0000, 1'b0, 4'b0000, 2'd3};
        vecs[18] = '{4'b1001, 1'b1, 4'b0001, 2'd0};
        vecs[19] = '{4'b1000, 1'b1, 4'b1000, 2'd3};
        vecs[20] = '{4'b0001, 1'b0, 4'b0001, 2'd0};

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].req, vecs[i].done);
            check_outputs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, 1'b0);
        end

        // Asynchronous reset while requester 2 owns the port.
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        check_outputs("pre_rst", 4'b0100, 2'd2, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111, 1'b0);
        check_outputs("post_rst", 4'b0001, 2'd0, 1'b0);

        // Owner 0 never signals done.
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= 3; i++) begin
            step(4'b0011, 1'b0);
            check_outputs($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b0);
        end
        step(4'b0011, 1'b0);
        check_outputs("hold_expire", 4'b0010, 2'd1, 1'b1);
        step(4'b0011, 1'b0);
        check_outputs("after_expire", 4'b0010, 2'd1, 1'b0);
`else
        for (int i = 1; i <= 20; i++) begin
            step(4'b0011, 1'b0);
            check_outputs($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
